// File: rtl/alu4_result_stage.sv
// alu4_result_stage
//   Registered output stage behind the 4-bit ALU operation units. Accepts a
//   result with carry/overflow. Derives the {N,Z,C,V} flags on the input side.
//   Presents result and flags through a valid/ready interface. A 2-entry skid
//   buffer (main + skid) means backpressure never drops or duplicates a result.
//   The stage also keeps sticky flags and a wrapping transfer counter.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   in_result, in_carry,
//   in_ovf, in_is_arith        ALU result and adder status
//   out_valid / out_ready      downstream handshake
//   out_result, out_flags      registered result and its {N,Z,C,V}
//   sticky_flags, sticky_clr   accumulated flags over transfers, clear input
//   xfer_count                 number of output transfers, wrapping
module alu4_result_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_ovf,
  input  logic             in_is_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] xfer_count
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_result_q, main_result_d;
  logic [3:0]       main_flags_q, main_flags_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic [3:0]       skid_flags_q, skid_flags_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       acc;
  logic       xfer;
  logic [3:0] in_flags;

  // in_ready depends only on registered state and rst, never on out_ready.
  assign in_ready = ~skid_valid_q & ~rst;
  assign acc      = in_valid & in_ready;
  assign xfer     = main_valid_q & out_ready;

  // C and V only mean something for add/sub results.
  assign in_flags = {in_result[WIDTH-1],
                     (in_result == '0),
                     in_is_arith & in_carry,
                     in_is_arith & in_ovf};

  always_comb begin
    main_valid_d  = main_valid_q;
    main_result_d = main_result_q;
    main_flags_d  = main_flags_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_flags_d  = skid_flags_q;
    sticky_d      = sticky_q;
    count_d       = count_q;

    if (!main_valid_q) begin
      if (acc) begin
        main_valid_d  = 1'b1;
        main_result_d = in_result;
        main_flags_d  = in_flags;
      end
    end else if (xfer) begin
      if (skid_valid_q) begin
        // in_ready is low whenever skid is full, so no accept can collide here.
        main_result_d = skid_result_q;
        main_flags_d  = skid_flags_q;
        skid_valid_d  = 1'b0;
      end else if (acc) begin
        main_result_d = in_result;
        main_flags_d  = in_flags;
      end else begin
        main_valid_d  = 1'b0;
      end
    end else if (acc) begin
      skid_valid_d  = 1'b1;
      skid_result_d = in_result;
      skid_flags_d  = in_flags;
    end

    // A clear coinciding with a transfer keeps that transfer's flags.
    if (xfer) begin
      sticky_d = sticky_clr ? main_flags_q : (sticky_q | main_flags_q);
      count_d  = count_q + 1'b1;
    end else if (sticky_clr) begin
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q  <= 1'b0;
      main_result_q <= '0;
      main_flags_q  <= '0;
      skid_valid_q  <= 1'b0;
      skid_result_q <= '0;
      skid_flags_q  <= '0;
      sticky_q      <= '0;
      count_q       <= '0;
    end else begin
      main_valid_q  <= main_valid_d;
      main_result_q <= main_result_d;
      main_flags_q  <= main_flags_d;
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      skid_flags_q  <= skid_flags_d;
      sticky_q      <= sticky_d;
      count_q       <= count_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_result   = main_result_q;
  assign out_flags    = main_flags_q;
  assign sticky_flags = sticky_q;
  assign xfer_count   = count_q;

endmodule

// File: tb/tb_alu4_result_stage.sv
module tb_alu4_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_carry;
  logic       in_ovf;
  logic       in_is_arith;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [3:0] sticky_flags;
  logic       sticky_clr;
  logic [7:0] xfer_count;

  always #5 clk = ~clk;

  alu4_result_stage #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_ovf(in_ovf),
    .in_is_arith(in_is_arith),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .xfer_count(xfer_count)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: FIFO of {result, flags} in acceptance order, capacity 2.
  logic [7:0] m_q[$];
  logic [3:0] m_sticky;
  logic [7:0] m_count;

  function automatic logic [3:0] flags_of(logic [3:0] r, logic c, logic v, logic arith);
    return {r[3], (r == 4'd0), arith & c, arith & v};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock, update the model, then compare every visible output.
  task automatic tick();
    logic m_acc, m_xfer;
    logic [7:0] front;
    m_acc  = in_valid && !rst && (m_q.size() < 2);
    m_xfer = (m_q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      m_q.delete();
      m_sticky = 4'd0;
      m_count  = 8'd0;
    end else begin
      if (m_xfer) begin
        front = m_q.pop_front();
        m_sticky = sticky_clr ? front[3:0] : (m_sticky | front[3:0]);
        m_count  = m_count + 8'd1;
      end else if (sticky_clr) begin
        m_sticky = 4'd0;
      end
      if (m_acc) m_q.push_back({in_result, flags_of(in_result, in_carry, in_ovf, in_is_arith)});
    end
    check("in_ready", in_ready, !rst && (m_q.size() < 2));
    check("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("out_result", out_result, m_q[0][7:4]);
      check("out_flags", out_flags, m_q[0][3:0]);
    end
    check("sticky_flags", sticky_flags, m_sticky);
    check("xfer_count", xfer_count, m_count);
  endtask

  task automatic drive(logic [3:0] r, logic c, logic v, logic a);
    in_valid = 1'b1; in_result = r; in_carry = c; in_ovf = v; in_is_arith = a;
  endtask

  typedef struct {
    logic [3:0] result;
    logic       carry;
    logic       ovf;
    logic       arith;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] c0;
  logic [3:0] seq6[6];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = 4'd0; in_carry = 1'b0; in_ovf = 1'b0;
    in_is_arith = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    m_sticky = 4'd0; m_count = 8'd0;

    // Reset for two cycles.
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_sticky", sticky_flags, 0);
    check("rst_count", xfer_count, 0);
    rst = 1'b0;

    // Flag-rule vectors, expected flags written out by hand.
    vecs[0] = '{4'b1010 ^ 4'b1100, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{4'b1111 ^ 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0100};
    vecs[2] = '{4'b1000,           1'b1, 1'b1, 1'b1, 4'b1011};
    vecs[3] = '{4'b0111,           1'b0, 1'b1, 1'b1, 4'b0001};
    vecs[4] = '{4'b1111,           1'b1, 1'b0, 1'b0, 4'b1000};
    vecs[5] = '{4'b0000,           1'b1, 1'b0, 1'b1, 4'b0110};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].result, vecs[i].carry, vecs[i].ovf, vecs[i].arith);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_result", i), out_result, vecs[i].result);
      check($sformatf("vec%0d_flags", i), out_flags, vecs[i].exp_flags);
    end
    tick();

    // Backpressure: two results with output stalled.
    out_ready = 1'b0;
    drive(4'b0001, 1'b0, 1'b0, 1'b0); tick();
    drive(4'b0010, 1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    check("bp_in_ready", in_ready, 0);
    check("bp_hold", out_result, 4'b0001);
    tick(); tick();
    check("bp_hold2", out_result, 4'b0001);
    out_ready = 1'b1;
    tick();
    check("bp_second", out_result, 4'b0010);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Streaming, one per cycle.
    c0 = m_count;
    seq6 = '{4'b0000, 4'b1111, 4'b0110, 4'b1111, 4'b0000, 4'b0110};
    for (int i = 0; i < 6; i++) begin
      drive(seq6[i], 1'b0, 1'b0, 1'b0);
      tick();
      check($sformatf("stream%0d", i), out_result, seq6[i]);
    end
    in_valid = 1'b0;
    tick();
    check("stream_count", xfer_count, c0 + 8'd6);

    // Sticky flags and clear.
    out_ready = 1'b0; sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("clr_alone0", sticky_flags, 0);
    out_ready = 1'b1;
    drive(4'b1000, 1'b0, 1'b0, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0; tick();
    check("sticky_nz", sticky_flags, 4'b1100);
    drive(4'b0001, 1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0; sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("clr_with_xfer", sticky_flags, 4'b0000);
    drive(4'b1000, 1'b1, 1'b0, 1'b1); tick();
    in_valid = 1'b0; tick();
    drive(4'b0001, 1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0; sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("clr_then_set", sticky_flags, 4'b0000);
    drive(4'b1001, 1'b1, 1'b1, 1'b1); tick();
    in_valid = 1'b0; tick();
    check("sticky_set", sticky_flags, 4'b1011);
    drive(4'b0000, 1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0; sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("clr_keeps_xfer", sticky_flags, 4'b0100);
    out_ready = 1'b0; sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("clr_alone", sticky_flags, 0);
    out_ready = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_result   = 4'($urandom);
      in_carry    = 1'($urandom);
      in_ovf      = 1'($urandom);
      in_is_arith = 1'($urandom);
      out_ready   = ($urandom_range(0, 2) != 0);
      sticky_clr  = ($urandom_range(0, 9) == 0);
      tick();
    end
    in_valid = 1'b0; sticky_clr = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    // 256 transfers wrap the counter back to its start value.
    c0 = m_count;
    for (int i = 0; i < 256; i++) begin
      drive(4'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("wrap_count", xfer_count, c0);

    // Fill main and skid, then reset mid-operation.
    out_ready = 1'b0;
    drive(4'b1010, 1'b0, 1'b0, 1'b0); tick();
    drive(4'b0101, 1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    rst = 1'b1; tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_count", xfer_count, 0);
    tick();
    check("post_rst_valid2", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu4_result_stage.md
Name: alu4_result_stage

Overview:
- Registered output stage directly downstream of the four-bit ALU operation units (add/sub, and/or/xor).
- Captures the selected 4-bit result with carry/overflow, computes N/Z/C/V flags, and presents them through a valid/ready interface.
- Uses a 2-entry skid buffer so backpressure never drops or duplicates a result.
- Maintains sticky flags and a transfer counter for status readout.

Parameters:
- WIDTH, 4, result width in bits (N flag = bit WIDTH-1).
- CNT_W, 8, width of xfer_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept this cycle
- in_result  input  WIDTH  ALU result (e.g. a^b from the xor unit)
- in_carry  input  1  adder carry/borrow out; ignored when in_is_arith=0
- in_ovf  input  1  adder signed overflow; ignored when in_is_arith=0
- in_is_arith  input  1  1 = add/sub result, 0 = logic result
- out_valid  output  1  output holds a valid result
- out_ready  input  1  downstream accepts this cycle
- out_result  output  WIDTH  registered result
- out_flags  output  4  {N,Z,C,V} for out_result
- sticky_flags  output  4  OR of out_flags over all output transfers since last clear
- sticky_clr  input  1  clear sticky_flags
- xfer_count  output  CNT_W  number of output transfers, wrapping

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - While rst is high, all state clears: out_valid=0, out_result=0, out_flags=0, sticky_flags=0, xfer_count=0, skid entry empty.
  - in_ready=0 while rst is high.
  - rst overrides every other input, including mid-transfer; any held data is discarded.
- Handshake definitions:
  - Input accept (acc) = in_valid & in_ready.
  - Output transfer (xfer) = out_valid & out_ready.
  - out_result and out_flags hold stable while out_valid=1 and out_ready=0.
- Flag rules, evaluated on the input side and stored alongside the result:
  - Z = (in_result == 0).
  - N = in_result[WIDTH-1].
  - C = in_is_arith ? in_carry : 0.
  - V = in_is_arith ? in_ovf : 0.
- Storage:
  - Main register (drives the outputs) plus one skid register.
  - in_ready = ~skid_valid & ~rst, combinational from registered state only (no combinational path from out_ready).
- Latency: an accept in cycle T gives out_valid=1 in cycle T+1 when the main register is empty or draining. Throughput is 1 result/cycle while out_ready=1.
- Per-cycle update cases:
  - Main empty, acc: load main.
  - Main full, xfer, acc, skid empty: load main with the new input.
  - Main full, xfer, skid full: move skid into main, skid empties. No acc is possible, since in_ready=0.
  - Main full, no xfer, acc: load skid; in_ready=0 next cycle.
  - Main full, xfer, no acc, skid empty: out_valid=0 next cycle.
- Ordering: results leave in strict acceptance order; no loss, no duplication.
- Sticky flags:
  - On xfer, sticky_flags <= sticky_flags | out_flags.
  - On sticky_clr alone, sticky_flags <= 0.
  - sticky_clr together with xfer: sticky_flags <= out_flags of that transfer (clear first, then set).
- Counter: xfer_count increments by 1 per xfer and wraps from 2^CNT_W-1 to 0 with no saturation.

Test Plan:
- Reset and flags: assert rst for 2 cycles -> in_ready=0, out_valid=0, all outputs 0. Deassert, then send logic result 1010^1100=0110 -> next cycle out_result=0110, out_flags=0000.
- Zero and logic masking: logic result 1111^1111=0000 with in_carry=1, in_ovf=1 -> out_flags=0100 (Z only; C and V masked). Arith result 1000 with carry=1, ovf=1 -> out_flags=1011.
- Backpressure: out_ready=0, send R1=0001, R2=0010 on consecutive cycles -> in_ready=0 after R2; out_result holds 0001. Raise out_ready -> 0001 then 0010 delivered; in_ready returns to 1.
- Streaming: out_ready=1, 6 back-to-back inputs 0000,1111,0110,1111,0000,0110 -> outputs identical in order, one per cycle, 1-cycle latency, xfer_count=6.
- Sticky and clear: transfer 1000 (N), then 0000 (Z) -> sticky_flags=1100. Assert sticky_clr in the same cycle as a transfer of 0001 -> sticky_flags=0000. Clear alone -> 0000.
- Wrap and mid-op reset: 256 transfers -> xfer_count wraps to 0. Fill main and skid, then assert rst -> next cycle out_valid=0 and in_ready=0; after release, no stale data appears.
